// File: rtl/frame_drawer_pkg.sv
// Shared constants, state encoding and helpers for the frame_drawer pixel renderer.
// Optional feature macro: FRAME_DRAWER_GAMEOVER_FILL_EN (game-over full-screen fill).
package frame_drawer_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int BALL_SIZE  = 4;
  localparam int BALL_Y     = 100;
  localparam int LANE_Y0    = 8;
  localparam int LANE_PITCH = 24;
  localparam int PLAT_LEN   = 8;

  localparam logic [2:0] COL_BG       = 3'b000;
  localparam logic [2:0] COL_GAMEOVER = 3'b100;

  // S_FILL is only reachable when the fill feature is compiled in.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_BALL,
    S_DRAW_PLATS,
    S_DRAW_BALL,
    S_DONE,
    S_FILL
  } state_e;

  // A pixel is written only when it lands inside the visible screen.
  function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
    return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/frame_drawer_if.sv
// Bundle between the game controller / state updater and the frame_drawer.
// Optional feature macro: FRAME_DRAWER_GAMEOVER_FILL_EN (uses gameover).
//
// Handshake: start is a one-cycle request sampled only while busy is low;
// the frame's data inputs are captured on that same edge. done is a
// one-cycle pulse after the last pixel; start is accepted again from the
// following cycle. There is no back-pressure on the pixel stream: each cycle
// with plot high is one pixel write of x/y/colour.
interface frame_drawer_if;
  import frame_drawer_pkg::*;

  logic        start;
  logic [7:0]  prev_ball;
  logic [7:0]  curr_ball;
  logic [27:0] position_plats;
  logic [11:0] color_plats;
  logic [2:0]  color_ball;
  logic        gameover;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;
  state_e      dbg_state;

  modport master (
    output start, prev_ball, curr_ball, position_plats, color_plats, color_ball, gameover,
    input  x, y, colour, plot, busy, done, dbg_state
  );

  modport slave (
    input  start, prev_ball, curr_ball, position_plats, color_plats, color_ball, gameover,
    output x, y, colour, plot, busy, done, dbg_state
  );
endinterface

// File: rtl/frame_drawer_rect_scan.sv
// Raster counter over a w x h rectangle (dx fastest). Wraps to the origin
// after the final pixel so consecutive rectangles need no reload.
module rect_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] w,
  input  logic [7:0] h,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic       last
);
  logic [7:0] dx_d, dx_q, dy_d, dy_q;

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == w - 8'd1) && (dy_q == h - 8'd1);

  // Next counter position: clear on load, otherwise advance in raster order.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (load) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en) begin
      if (dx_q == w - 8'd1) begin
        dx_d = '0;
        dy_d = (dy_q == h - 8'd1) ? 8'd0 : dy_q + 8'd1;
      end else begin
        dx_d = dx_q + 8'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
endmodule

// File: rtl/frame_drawer.sv
// frame_drawer: turns one game tick into a pixel stream -- erase old ball,
// redraw four platforms, draw new ball -- one registered pixel per cycle.
// Optional feature macro: FRAME_DRAWER_GAMEOVER_FILL_EN (game-over fill pass).
module frame_drawer
  import frame_drawer_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  frame_drawer_if.slave  bus
);
  state_e      state_d, state_q;
  logic [1:0]  lane_d, lane_q;
  logic [7:0]  prev_d, prev_q, curr_d, curr_q;
  logic [27:0] pos_d, pos_q;
  logic [11:0] pcol_d, pcol_q;
  logic [2:0]  bcol_d, bcol_q;
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
  logic        go_d, go_q;
`endif
  logic [7:0]  x_d, x_q;
  logic [6:0]  y_d, y_q;
  logic [2:0]  colour_d, colour_q;
  logic        plot_d, plot_q, busy_d, busy_q, done_d, done_q;

  logic        scan_load, scan_en, scan_last;
  logic [7:0]  scan_w, scan_h, dx, dy;
  logic [8:0]  px;
  logic [7:0]  py;
  logic [2:0]  pcolour;
  logic        pix_valid;

  rect_scan u_scan (
    .clk(clk), .reset(reset), .load(scan_load), .en(scan_en),
    .w(scan_w), .h(scan_h), .dx(dx), .dy(dy), .last(scan_last)
  );

  // Rectangle dimensions for the pass currently running.
  always_comb begin
    scan_w = 8'(BALL_SIZE);
    scan_h = 8'(BALL_SIZE);
    case (state_q)
      S_DRAW_PLATS: begin
        scan_w = 8'd1;
        scan_h = 8'(PLAT_LEN);
      end
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
      S_FILL: begin
        scan_w = 8'(SCREEN_W);
        scan_h = 8'(SCREEN_H);
      end
`endif
      default: ;
    endcase
  end

  // Pixel coordinate/colour for this cycle, 9-bit x so off-screen balls clip.
  always_comb begin
    px        = '0;
    py        = '0;
    pcolour   = COL_BG;
    pix_valid = 1'b0;
    case (state_q)
      S_ERASE_BALL: begin
        px        = {1'b0, prev_q} + {1'b0, dx};
        py        = 8'(BALL_Y) + dy;
        pix_valid = 1'b1;
      end
      S_DRAW_PLATS: begin
        px        = {2'b00, pos_q[7*lane_q +: 7]};
        py        = 8'(LANE_Y0) + 8'(lane_q) * 8'(LANE_PITCH) + dy;
        pcolour   = pcol_q[3*lane_q +: 3];
        pix_valid = 1'b1;
      end
      S_DRAW_BALL: begin
        px        = {1'b0, curr_q} + {1'b0, dx};
        py        = 8'(BALL_Y) + dy;
        pcolour   = bcol_q;
        pix_valid = 1'b1;
      end
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
      S_FILL: begin
        px        = {1'b0, dx};
        py        = dy;
        pcolour   = COL_GAMEOVER;
        pix_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Next state, shadow capture on accepted start, and registered outputs.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    prev_d    = prev_q;
    curr_d    = curr_q;
    pos_d     = pos_q;
    pcol_d    = pcol_q;
    bcol_d    = bcol_q;
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
    go_d      = go_q;
`endif
    scan_load = 1'b0;
    scan_en   = pix_valid;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          prev_d    = bus.prev_ball;
          curr_d    = bus.curr_ball;
          pos_d     = bus.position_plats;
          pcol_d    = bus.color_plats;
          bcol_d    = bus.color_ball;
          lane_d    = 2'd0;
          scan_load = 1'b1;
          state_d   = S_ERASE_BALL;
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
          go_d      = bus.gameover;
          if (bus.gameover) state_d = S_FILL;
`endif
        end
      end
      S_ERASE_BALL: if (scan_last) state_d = S_DRAW_PLATS;
      S_DRAW_PLATS: begin
        if (scan_last) begin
          if (lane_q == 2'd3) state_d = S_DRAW_BALL;
          else                lane_d  = lane_q + 2'd1;
        end
      end
      S_DRAW_BALL:  if (scan_last) state_d = S_DONE;
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
      S_FILL:       if (scan_last) state_d = S_DONE;
`endif
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (pix_valid) begin
      x_d      = px[7:0];
      y_d      = py[6:0];
      colour_d = pcolour;
    end
    plot_d = pix_valid && on_screen(px, py);
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      prev_q   <= '0;
      curr_q   <= '0;
      pos_q    <= '0;
      pcol_q   <= '0;
      bcol_q   <= '0;
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
      go_q     <= 1'b0;
`endif
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      prev_q   <= prev_d;
      curr_q   <= curr_d;
      pos_q    <= pos_d;
      pcol_q   <= pcol_d;
      bcol_q   <= bcol_d;
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
      go_q     <= go_d;
`endif
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_frame_drawer.sv
// Testbench for frame_drawer: a frame-level model expands each accepted start
// into the expected per-cycle output stream; a compare process checks every
// cycle, and directed frames pin the model with hand-computed pixels.
module tb_frame_drawer;
  import frame_drawer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_drawer_if bus ();

  frame_drawer dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       plot;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } rec_t;
  localparam int W = $bits(rec_t);

  logic [W-1:0] exp_q[$];
  int acc_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit armed = 1'b0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int log_x[$], log_y[$], log_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  task automatic push_rec(input int px, input int py, input int c, input bit b, input bit d);
    rec_t r;
    r.plot = (px < 160) && (py < 120) && b && !d;
    r.busy = b;
    r.done = d;
    r.x    = 8'(px);
    r.y    = 7'(py);
    r.col  = 3'(c);
    exp_q.push_back(W'(r));
  endtask

  // Whole frame as the screen should see it, one entry per cycle from the accept cycle.
  task automatic model_frame();
    int pb, cb, bc;
    pb = int'(bus.prev_ball);
    cb = int'(bus.curr_ball);
    bc = int'(bus.color_ball);
    push_rec(0, 0, 0, 1'b0, 1'b0);
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
    if (bus.gameover) begin
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++) push_rec(xx, yy, 4, 1'b1, 1'b0);
      push_rec(0, 0, 0, 1'b1, 1'b1);
      return;
    end
`endif
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) push_rec(pb + xx, 100 + yy, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++)
        push_rec(int'(bus.position_plats[7*i +: 7]), 8 + 24 * i + k,
                 int'(bus.color_plats[3*i +: 3]), 1'b1, 1'b0);
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) push_rec(cb + xx, 100 + yy, bc, 1'b1, 1'b0);
    push_rec(0, 0, 0, 1'b1, 1'b1);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) exp_q.delete();
    else if (bus.start && exp_q.size() == 0) begin
      acc_q.push_back(cyc);
      model_frame();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    rec_t e;
    if (armed) begin
      if (exp_q.size() > 0) e = rec_t'(exp_q.pop_front());
      else                  e = '0;
      check("plot", bus.plot, e.plot);
      check("busy", bus.busy, e.busy);
      check("done", bus.done, e.done);
      if (e.plot) begin
        check("x", bus.x, e.x);
        check("y", bus.y, e.y);
        check("colour", bus.colour, e.col);
      end
      if (bus.plot === 1'b1) begin
        plot_cnt++;
        log_x.push_back(int'(bus.x));
        log_y.push_back(int'(bus.y));
        log_c.push_back(int'(bus.colour));
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    plot_cnt = 0;
    log_x.delete();
    log_y.delete();
    log_c.delete();
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 25000) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) check("frame_timeout", 1, 0);
    step(2);
  endtask

  task automatic check_last(input string tag, input int ex, input int ey, input int ec);
    if (plot_cnt > 0) begin
      check({tag, "_last_x"}, log_x[$], ex);
      check({tag, "_last_y"}, log_y[$], ey);
      check({tag, "_last_c"}, log_c[$], ec);
    end else check({tag, "_no_plots"}, 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0, n0;
    bus.start          = 1'b0;
    bus.prev_ball      = 8'd20;
    bus.curr_ball      = 8'd21;
    bus.position_plats = {7'd70, 7'd50, 7'd30, 7'd10};
    bus.color_plats    = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.color_ball     = 3'd5;
    bus.gameover       = 1'b0;

    step(3);
    reset = 1'b0;
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_colour", bus.colour, 0);
    check("rst_plot", bus.plot, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    armed = 1'b1;
    step(10);

    // Frame A: nominal; inputs changed mid-frame must not be re-read.
    clear_log();
    start_frame();
    bus.prev_ball = 8'd99;
    bus.curr_ball = 8'd0;
    wait_frame();
    check("a_plots", plot_cnt, 64);
    if (plot_cnt == 64) begin
      check("a_first_x", log_x[0], 20);
      check("a_first_y", log_y[0], 100);
      check("a_first_c", log_c[0], 0);
      check("a_p17_x", log_x[16], 10);
      check("a_p17_y", log_y[16], 8);
      check("a_p17_c", log_c[16], 1);
    end
    check_last("a", 24, 103, 5);
    check("a_done_lat", done_cyc - acc_q[$], 65);

    // Frame B: ball at the right edge, dx 2/3 clipped.
    bus.prev_ball = 8'd21;
    bus.curr_ball = 8'd158;
    clear_log();
    start_frame();
    wait_frame();
    check("b_plots", plot_cnt, 56);
    check_last("b", 159, 103, 5);
    check("b_done_lat", done_cyc - acc_q[$], 65);

    // Starts at relative cycles 0, 10, 65 (DONE) and 66.
    n0 = acc_q.size();
    start_frame();
    step(9);
    start_frame();
    step(54);
    bus.start = 1'b1;
    step(2);
    bus.start = 1'b0;
    wait_frame();
    check("bb_accepts", acc_q.size() - n0, 2);
    if (acc_q.size() >= 2) check("bb_period", acc_q[$] - acc_q[$-1], 66);

    // Reset mid-frame: outputs drop and no done is issued.
    d0 = done_cnt;
    start_frame();
    step(29);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_plot", bus.plot, 0);
    check("mid_rst_busy", bus.busy, 0);
    step(80);
    check("mid_rst_no_done", done_cnt - d0, 0);

    // Old ball off-screen, black platforms and ball, platform x at 127.
    bus.prev_ball      = 8'd200;
    bus.curr_ball      = 8'd5;
    bus.position_plats = {7'd127, 7'd0, 7'd64, 7'd1};
    bus.color_plats    = 12'd0;
    bus.color_ball     = 3'd0;
    clear_log();
    start_frame();
    wait_frame();
    check("c_plots", plot_cnt, 48);
    check_last("c", 8, 103, 0);
    check("c_done_lat", done_cyc - acc_q[$], 65);

    // Game-over frame.
    bus.prev_ball      = 8'd20;
    bus.curr_ball      = 8'd21;
    bus.position_plats = {7'd70, 7'd50, 7'd30, 7'd10};
    bus.color_plats    = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.color_ball     = 3'd5;
    bus.gameover       = 1'b1;
    clear_log();
    start_frame();
    bus.gameover = 1'b0;
    wait_frame();
`ifdef FRAME_DRAWER_GAMEOVER_FILL_EN
    check("go_plots", plot_cnt, 19200);
    check_last("go", 159, 119, 4);
    check("go_done_lat", done_cyc - acc_q[$], 19201);
`else
    check("go_plots", plot_cnt, 64);
    check_last("go", 24, 103, 5);
    check("go_done_lat", done_cyc - acc_q[$], 65);
`endif
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/frame_drawer.md
# frame_drawer

Pixel renderer for the colour-bounce game: consumes the state produced by the per-tick game-state update (previous/current ball position, platform positions and colours, ball colour, gameover) and turns it into a serial stream of single-pixel writes for the VGA adapter. One frame update is started by a pulse from the game controller and acknowledged with a one-cycle done pulse. Order per frame: erase old ball, redraw four platforms, draw new ball.

## Interface
- BALL_Y, 100: top row of the 4x4 ball sprite.
- LANE_Y0, 8: top row of platform lane 0.
- LANE_PITCH, 24: row offset between consecutive lanes.
- PLAT_LEN, 8: platform height in pixels (platform is 1 px wide).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request from controller; ignored unless idle.
- prev_ball  in  8  ball x before the update.
- curr_ball  in  8  ball x after the update.
- position_plats  in  28  four 7-bit platform x positions; lane i at [7i+6:7i].
- color_plats  in  12  four 3-bit platform colours; lane i at [3i+2:3i].
- color_ball  in  3  ball colour.
- gameover  in  1  game-over flag from the updater.
- x  out  8  pixel column.
- y  out  7  pixel row.
- colour  out  3  pixel colour.
- plot  out  1  write-enable for the current x/y/colour.
- busy  out  1  high while not idle.
- done  out  1  one-cycle pulse after the last pixel of a frame.

## Operation
- States: IDLE, ERASE_BALL, DRAW_PLATS, DRAW_BALL, DONE (plus FILL under the macro).
- IDLE: on start, latch all data inputs into shadow registers; go to ERASE_BALL. Inputs are not re-read mid-frame.
- ERASE_BALL: 16 pixels, x = prev_ball+dx, y = BALL_Y+dy, dx/dy 0..3 raster order (dx fastest), colour 3'b000.
- DRAW_PLATS: lanes 0..3 in order; per lane PLAT_LEN pixels, x = pos_i, y = LANE_Y0 + i*LANE_PITCH + k, k = 0..PLAT_LEN-1, colour = colour_i.
- DRAW_BALL: as ERASE_BALL with curr_ball and color_ball.
- DONE: done=1 for one cycle, return to IDLE.
- Clipping: x computed 9-bit; if x >= 160 or y >= 120, pixel still consumes its cycle but plot=0. Ball positions >= 160 are therefore fully suppressed.
- Colour 3'b000 for platforms/ball is legal and drawn as written.

## Timing
- Reset values: state IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0, shadow registers 0.
- All outputs registered. start accepted at cycle 0 -> first pixel (plot) at cycle 1.
- One pixel per cycle, no stalls. Pixel count N = 32 + 4*PLAT_LEN (64 at defaults); last pixel at cycle N, done at cycle N+1, busy high cycles 1..N+1.
- start during busy (including the DONE cycle): ignored, no queueing.
- start in the cycle after done: accepted normally (back-to-back frames, period N+2).
- reset mid-frame: next cycle IDLE, plot=0, done not issued.

## Configuration
- FRAME_DRAWER_GAMEOVER_FILL_EN defined: if latched gameover=1 at start, enter FILL instead of ERASE_BALL; write all 160x120 pixels, raster order, colour 3'b100, then DONE (done at cycle 19201). gameover=0 frames unchanged.
- Undefined: gameover is ignored; every frame uses the normal sequence.

## Structure
- Package frame_drawer_pkg: state enum, SCREEN_W=160, SCREEN_H=120, COL_BG=3'b000, COL_GAMEOVER=3'b100, BALL_SIZE=4.
- Sub-module rect_scan: counts dx/dy over a W x H rectangle on enable, raises last on the final pixel, clears on load; reused for ball, platform, and fill passes.

## Test plan
- Reset then idle 10 cycles -> plot=0, busy=0, done=0 throughout.
- prev_ball=20, curr_ball=21, plats x=10,30,50,70 colours 1,2,3,4, color_ball=5, start -> 64 plots; first (20,100,0), pixel 17 is (10,8,1), last (24,103,5); done at cycle 65.
- curr_ball=158 -> ball pixels with dx 2,3 have plot=0; frame length still 64, done at 65.
- start pulsed at cycles 0, 10, 65 -> only cycle-0 start accepted; cycle-65 start during DONE ignored; start at cycle 66 starts a new frame.
- Reset asserted at cycle 30 -> plot=0 and busy=0 from cycle 31, no done pulse.
- With FRAME_DRAWER_GAMEOVER_FILL_EN, gameover=1, start -> 19200 plots colour 3'b100, last (159,119), done at cycle 19201; without macro same stimulus -> normal 64-pixel frame.
